aes192_inv_cipher_iter: RTL and testbench

Iterative AES-192 inverse cipher (decryption) core: one round per clock, built on the same column-major 128-bit state layout as the encrypt path. It accepts a ciphertext block through a valid/ready handshake and fetches round keys from an external key store by index. It returns the plaintext through a second valid/ready handshake. It sits opposite the combinational encrypt datapath and shares its byte ordering, so encrypt and decrypt outputs round-trip bit-exactly.

---
 rtl/aes_pkg.sv | 126 ++++++++++++
 rtl/inv_shift_rows.sv | 19 +
 rtl/aes192_inv_cipher_iter.sv | 98 +++++++++
 tb/tb_aes192_inv_cipher_iter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the inverse cipher.
// Exports aes_state_t, NR_192, fsm_e, gmul, inv_sbox and inv_mix_column.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    localparam logic [3:0] NR_192 = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;

    // Shift-and-add multiply, reducing by 0x11b on each doubling.
    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Column word: row 0 in [31:24], row 3 in [7:0].
    function automatic logic [31:0] inv_mix_column(
        input logic [31:0] c
    );
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        o0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
           ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
           ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
           ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
           ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        return {o0, o1, o2, o3};
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        case (x)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5;
            8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e;
            8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82;
            8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44;
            8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32;
            8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b;
            8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66;
            8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49;
            8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64;
            8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc;
            8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50;
            8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57;
            8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00;
            8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05;
            8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f;
            8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03;
            8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41;
            8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce;
            8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22;
            8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8;
            8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71;
            8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e;
            8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b;
            8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe;
            8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33;
            8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59;
            8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9;
            8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f;
            8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d;
            8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c;
            8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e;
            8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63;
            8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state rotates right by r bytes.
// Ports: i_state (128, byte k = row k%4, col k/4), o_state (128).
module inv_shift_rows
    import aes_pkg::*;
(
    input  aes_state_t i_state,
    output aes_state_t o_state
);

    // new[row r][col c] = old[row r][col (c - r) mod 4]
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign o_state[127-8*DST -: 8] = i_state[127-8*SRC -: 8];
        end
    end

endmodule

// File: rtl/aes192_inv_cipher_iter.sv
// Iterative AES-192 decrypt core, one round per clock, external key store.
// Ports: clk, rst (async high); in_valid/in_ready/data_in ciphertext side;
// rk_idx/rk key-store lookup; out_valid/out_ready/data_out plaintext side.
module aes192_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    fsm_e       r_fsm;
    fsm_e       w_fsm_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    aes_state_t r_state;
    aes_state_t w_state_nxt;

    aes_state_t w_isr;
    aes_state_t w_isb;
    aes_state_t w_add;
    aes_state_t w_imc;

    inv_shift_rows u_isr (
        .i_state (r_state),
        .o_state (w_isr)
    );

    for (genvar g = 0; g < 16; g++) begin : g_sb
        assign w_isb[127-8*g -: 8] = inv_sbox(w_isr[127-8*g -: 8]);
    end

    assign w_add = w_isb ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_mc
        assign w_imc[127-32*c -: 32] = inv_mix_column(w_add[127-32*c -: 32]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_cnt   <= 4'd0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode only from r_fsm/r_cnt, so in_valid and out_ready
    // never reach an output combinationally.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        rk_idx      = r_cnt;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = NR_192;
                if (in_valid) begin
                    w_state_nxt = data_in ^ rk;
                    w_cnt_nxt   = NR_192 - 4'd1;
                    w_fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                w_state_nxt = w_imc;
                w_cnt_nxt   = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_fsm_nxt = FINAL;
            end
            FINAL: begin
                // Last round skips InvMixColumns; counter already at 0.
                w_state_nxt = w_add;
                w_fsm_nxt   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                rk_idx    = 4'd0;
                if (out_ready) w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    assign data_out = r_state;

endmodule

// File: tb/tb_aes192_inv_cipher_iter.sv
// Self-checking bench for aes192_inv_cipher_iter.
// Known-answer table, handshake corner cases, reset abort, round trips.
module tb_aes192_inv_cipher_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    logic [127:0] rk_mem [0:15];
    logic [7:0]   sbox_f [0:255];

    logic [127:0] isr_in;
    logic [127:0] isr_out;

    int n_chk;
    int n_fail;

    assign rk = rk_mem[rk_idx];

    aes192_inv_cipher_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    inv_shift_rows u_isr_iso (
        .i_state (isr_in),
        .o_state (isr_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [191:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vec [0:4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic chk4(input string nm, input logic [3:0] act,
                        input logic [3:0] exp);
        chk(nm, {124'd0, act}, {124'd0, exp});
    endtask

    // Independent GF(2^8) multiply for the reference model.
    function automatic logic [7:0] tgm(input logic [7:0] a,
                                       input logic [7:0] b);
        logic [15:0] p;
        p = 16'd0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'd0, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tgm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_f[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2)
                      ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_f[w[31:24]], sbox_f[w[23:16]],
                sbox_f[w[15:8]], sbox_f[w[7:0]]};
    endfunction

    task automatic expand(input logic [191:0] key);
        logic [31:0] w [0:51];
        logic [31:0] t;
        for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0)
                t = subw({t[23:0], t[31:24]})
                  ^ {8'h01 << (i / 6 - 1), 24'h0};
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++)
            rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] =
                    sbox_f[s[127-8*(4*((c+r)%4)+r) -: 8]];
        return t;
    endfunction

    function automatic logic [127:0] mixc(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t[127-32*c -: 8] = tgm(a0, 2) ^ tgm(a1, 3) ^ a2 ^ a3;
            t[119-32*c -: 8] = a0 ^ tgm(a1, 2) ^ tgm(a2, 3) ^ a3;
            t[111-32*c -: 8] = a0 ^ a1 ^ tgm(a2, 2) ^ tgm(a3, 3);
            t[103-32*c -: 8] = tgm(a0, 3) ^ a1 ^ a2 ^ tgm(a3, 2);
        end
        return t;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_mem[0];
        for (int r = 1; r <= 12; r++) begin
            s = sub_shift(s);
            if (r != 12) s = mixc(s);
            s = s ^ rk_mem[r];
        end
        return s;
    endfunction

    // Leaves the core in DONE with the result on data_out.
    task automatic run_block(input logic [127:0] ct, input bit seq,
                             output logic [127:0] pt);
        int n;
        data_in  = ct;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk1("accept_ready", in_ready, 1'b1);
        if (seq) chk4("rk_idx_accept", rk_idx, 4'd12);
        tick();
        in_valid = 1'b0;
        if (seq) begin
            for (int k = 0; k < 12; k++) begin
                chk4("rk_idx_seq", rk_idx, 4'(11 - k));
                chk1("out_valid_early", out_valid, 1'b0);
                tick();
            end
            chk1("out_valid_lat12", out_valid, 1'b1);
        end else begin
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk1("out_valid_timeout", out_valid, 1'b1);
        end
        pt = data_out;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [191:0] key;
        int n;

        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        isr_in    = '0;
        for (int i = 0; i < 16; i++) rk_mem[i] = '0;

        vec[0] = '{192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                   128'h00112233445566778899aabbccddeeff};
        vec[1] = '{192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                   128'hbd334f1d6e45f25ff712a214571fa5cc,
                   128'h6bc1bee22e409f96e93d7e117393172a};
        vec[2] = '{192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                   128'h974104846d0ad3ad7734ecb3ecee4eef,
                   128'hae2d8a571e03ac9c9eb76fac45af8e51};
        vec[3] = '{192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                   128'hef7afd2270e2e60adce0ba2face6444e,
                   128'h30c81c46a35ce411e5fbc1191a0a52ef};
        vec[4] = '{192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                   128'h9a4b41ba738d6c72fb16691603c18e0e,
                   128'hf69f2445df4f9b17ad2b417be66c3710};

        build_sbox();
        chk("model_sbox_00", {120'd0, sbox_f[0]}, 128'h63);
        chk("model_sbox_53", {120'd0, sbox_f[8'h53]}, 128'hed);

        #2 rst = 1'b1;
        tick();
        tick();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_data_out", data_out, 128'd0);
        chk4("rst_rk_idx", rk_idx, 4'd12);
        #2 rst = 1'b0;
        tick();

        isr_in = 128'h000102030405060708090a0b0c0d0e0f;
        #1;
        chk("isr_iso", isr_out, 128'h000d0a0704010e0b0805020f0c090603);

        for (int i = 0; i < 5; i++) begin
            expand(vec[i].key);
            chk("model_enc", enc(vec[i].pt), vec[i].ct);
            run_block(vec[i].ct, i == 0, got);
            chk("kat_pt", got, vec[i].pt);
            drain();
        end

        // Backpressure: hold DONE, offer another block meanwhile.
        expand(vec[1].key);
        run_block(vec[1].ct, 1'b0, got);
        data_in  = vec[2].ct;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk1("bp_out_valid", out_valid, 1'b1);
            chk("bp_data_out", data_out, vec[1].pt);
            chk1("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("bp_idle_ready", in_ready, 1'b1);
        chk1("bp_idle_valid", out_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        chk4("bp_accepted", rk_idx, 4'd11);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk1("bp2_valid", out_valid, 1'b1);
        chk("bp2_pt", data_out, vec[2].pt);
        drain();

        // Reset mid-round, then decode a fresh block under another key.
        expand(vec[0].key);
        data_in  = vec[0].ct;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4'd6 && n < 20) begin
            tick();
            n++;
        end
        chk4("mid_rk_idx6", rk_idx, 4'd6);
        #2 rst = 1'b1;
        #1;
        chk1("arst_in_ready", in_ready, 1'b1);
        chk1("arst_out_valid", out_valid, 1'b0);
        chk("arst_data_out", data_out, 128'd0);
        chk4("arst_rk_idx", rk_idx, 4'd12);
        tick();
        #2 rst = 1'b0;
        tick();
        expand(vec[3].key);
        run_block(vec[3].ct, 1'b0, got);
        chk("post_rst_pt", got, vec[3].pt);
        drain();

        for (int i = 0; i < 1000; i++) begin
            key = {$urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            ct = enc(pt);
            run_block(ct, 1'b0, got);
            chk("roundtrip", got, pt);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
